// File: rtl/prog_mem_pkg.sv
// Shared CPU program-memory definitions: loader FSM state encoding and the NOP word.
package prog_mem_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_CLEAR = 2'd0;
  localparam state_t ST_IDLE  = 2'd1;
  localparam state_t ST_LOAD  = 2'd2;
  localparam state_t ST_FILL  = 2'd3;

  // NOP is the all-zero instruction; replicate to any word width.
  localparam logic NOP_BIT = 1'b0;

endpackage

// File: rtl/prog_mem_if.sv
// Fetch and program-load bus between the CPU/loader side and prog_mem.
interface prog_mem_if #(
  parameter int DATA_W = 35,
  parameter int ADDR_W = 8
);
  logic              fetch_en;
  logic [ADDR_W-1:0] fetch_addr;
  logic [DATA_W-1:0] fetch_data;
  logic              fetch_valid;
  logic              load_start;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_last;
  logic              load_ready;
  logic              cpu_hold;
  logic              load_done;
  logic              load_err;
  logic [DATA_W-1:0] checksum;

  modport master (
    output fetch_en, fetch_addr, load_start, load_valid, load_data, load_last,
    input  fetch_data, fetch_valid, load_ready, cpu_hold, load_done, load_err, checksum
  );

  modport slave (
    input  fetch_en, fetch_addr, load_start, load_valid, load_data, load_last,
    output fetch_data, fetch_valid, load_ready, cpu_hold, load_done, load_err, checksum
  );
endinterface

// File: rtl/prog_mem_ram.sv
// Single-port synchronous RAM with registered read; no reset so it maps to block RAM.
module prog_mem_ram #(
  parameter  int DATA_W = 35,
  parameter  int DEPTH  = 256,
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
    if (re) rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/prog_mem.sv
// CPU program memory: clears itself after reset, accepts a streamed program load
// with NOP padding, and serves 1-cycle-latency instruction fetches while idle.
module prog_mem
  import prog_mem_pkg::*;
#(
  parameter int DATA_W = 35,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  prog_mem_if.slave   bus
);

  localparam int               RAM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]  DEPTH_P = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]  LAST_P  = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W:0]  PTR_ONE = (ADDR_W + 1)'(1);

  state_t            state_q, state_d;
  logic [ADDR_W:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0] chk_q, chk_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic              fvalid_q, fvalid_d;
  logic              fzero_q, fzero_d;

  logic              ram_we, ram_re;
  logic [RAM_AW-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;
  logic              fetch_in_range;

  assign fetch_in_range = {1'b0, bus.fetch_addr} < DEPTH_P;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    chk_d     = chk_q;
    err_d     = err_q;
    done_d    = 1'b0;
    fvalid_d  = 1'b0;
    fzero_d   = fzero_q;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_wdata = {DATA_W{NOP_BIT}};

    // fzero_q masks the RAM read register so out-of-range and busy fetches read as NOP.
    if (bus.fetch_en && state_q != ST_IDLE) fzero_d = 1'b1;

    case (state_q)
      ST_CLEAR: begin
        ram_we = 1'b1;
        ptr_d  = ptr_q + PTR_ONE;
        if (ptr_q == LAST_P) begin
          ptr_d   = '0;
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (bus.fetch_en) begin
          fvalid_d = 1'b1;
          fzero_d  = !fetch_in_range;
          ram_re   = fetch_in_range;
        end
        if (bus.load_start) begin
          ptr_d   = '0;
          chk_d   = '0;
          err_d   = 1'b0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (bus.load_valid) begin
          if (ptr_q == DEPTH_P) begin
            err_d = 1'b1;
          end else begin
            ram_we    = 1'b1;
            ram_wdata = bus.load_data;
            ptr_d     = ptr_q + PTR_ONE;
            chk_d     = chk_q ^ bus.load_data;
          end
          if (bus.load_last) state_d = ST_FILL;
        end
      end
      default: begin
        // FILL: pad with NOPs, then one extra cycle to signal completion.
        if (ptr_q == DEPTH_P) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          ram_we = 1'b1;
          ptr_d  = ptr_q + PTR_ONE;
        end
      end
    endcase
  end

  assign ram_addr = (state_q == ST_IDLE) ? bus.fetch_addr[RAM_AW-1:0] : ptr_q[RAM_AW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_CLEAR;
      ptr_q    <= '0;
      chk_q    <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      fvalid_q <= 1'b0;
      fzero_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      chk_q    <= chk_d;
      err_q    <= err_d;
      done_q   <= done_d;
      fvalid_q <= fvalid_d;
      fzero_q  <= fzero_d;
    end
  end

  prog_mem_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign bus.fetch_data  = fzero_q ? {DATA_W{NOP_BIT}} : ram_rdata;
  assign bus.fetch_valid = fvalid_q;
  assign bus.load_ready  = (state_q == ST_LOAD);
  assign bus.cpu_hold    = (state_q != ST_IDLE);
  assign bus.load_done   = done_q;
  assign bus.load_err    = err_q;
  assign bus.checksum    = chk_q;

endmodule

// File: tb/tb_prog_mem.sv
// Scoreboard bench for prog_mem: three instances (DEPTH 256, 4, 200) driven by directed vectors.
module tb_prog_mem;
  localparam int DW = 35;
  localparam int AW = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          fe[3], ls[3], lv[3], ll[3];
  logic [AW-1:0] fa[3];
  logic [DW-1:0] ldat[3];
  logic [DW-1:0] fd[3], cs[3];
  logic          fv[3], lr[3], ch[3], ldn[3], le[3];

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int D = (gi == 0) ? 256 : (gi == 1) ? 4 : 200;
    prog_mem_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
    prog_mem #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(D)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
    );
    assign bus.fetch_en   = fe[gi];
    assign bus.fetch_addr = fa[gi];
    assign bus.load_start = ls[gi];
    assign bus.load_valid = lv[gi];
    assign bus.load_data  = ldat[gi];
    assign bus.load_last  = ll[gi];
    assign fd[gi]  = bus.fetch_data;
    assign fv[gi]  = bus.fetch_valid;
    assign lr[gi]  = bus.load_ready;
    assign ch[gi]  = bus.cpu_hold;
    assign ldn[gi] = bus.load_done;
    assign le[gi]  = bus.load_err;
    assign cs[gi]  = bus.checksum;
  end

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] exp_q0[$], exp_q1[$], exp_q2[$];

  task automatic check_word(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic check_int(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic score(int i, logic [DW-1:0] act);
    logic [DW-1:0] e;
    int sz;
    case (i)
      0:       sz = exp_q0.size();
      1:       sz = exp_q1.size();
      default: sz = exp_q2.size();
    endcase
    n_checks++;
    if (sz == 0) begin
      n_fail++;
      $display("FAIL fetch_unexpected dut%0d: got fetch_valid with data %h, required no response", i, act);
    end else begin
      case (i)
        0:       e = exp_q0.pop_front();
        1:       e = exp_q1.pop_front();
        default: e = exp_q2.pop_front();
      endcase
      $display("fetch dut%0d: data %h expected %h", i, act, e);
      if (act !== e) begin
        n_fail++;
        $display("FAIL fetch_data dut%0d: got %h, required %h", i, act, e);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(int i, int addr, logic [DW-1:0] exp);
    case (i)
      0:       exp_q0.push_back(exp);
      1:       exp_q1.push_back(exp);
      default: exp_q2.push_back(exp);
    endcase
    fe[i] = 1'b1;
    fa[i] = AW'(addr);
    tick();
    fe[i] = 1'b0;
  endtask

  task automatic start_load(int i);
    ls[i] = 1'b1;
    tick();
    ls[i] = 1'b0;
  endtask

  task automatic send(int i, logic [DW-1:0] d, logic last);
    lv[i]   = 1'b1;
    ldat[i] = d;
    ll[i]   = last;
    tick();
    lv[i] = 1'b0;
    ll[i] = 1'b0;
  endtask

  task automatic wait_idle(int i, int max, output int n);
    n = 0;
    while (ch[i] && n < max) begin
      tick();
      n++;
    end
  endtask

  task automatic count_done(int i, int cycles, output int pulses);
    pulses = 0;
    repeat (cycles) begin
      tick();
      if (ldn[i]) pulses++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    int n, p;
    for (int i = 0; i < 3; i++) begin
      fe[i] = 0; fa[i] = '0; ls[i] = 0; lv[i] = 0; ll[i] = 0; ldat[i] = '0;
    end
    rst_n = 1'b1;
    #1 rst_n = 1'b0;

    // Monitor: compares every presented fetch against the scoreboard.
    fork
      forever begin
        @(negedge clk);
        for (int i = 0; i < 3; i++) if (fv[i]) score(i, fd[i]);
      end
    join_none

    repeat (2) tick();
    check_word("reset fetch_data", fd[0], '0);
    check_int("reset fetch_valid", int'(fv[0]), 0);
    check_int("reset load_ready", int'(lr[0]), 0);
    check_int("reset cpu_hold", int'(ch[0]), 1);
    check_int("reset load_done", int'(ldn[0]), 0);
    check_int("reset load_err", int'(le[0]), 0);
    check_word("reset checksum", cs[0], '0);

    // Reset and clear sweep.
    rst_n = 1'b1;
    wait_idle(0, 400, n);
    check_int("clear cycles dut0", n, 256);
    check_int("cpu_hold dut1 after clear", int'(ch[1]), 0);
    check_int("cpu_hold dut2 after clear", int'(ch[2]), 0);
    fetch(0, 0, '0);
    fetch(0, 100, '0);
    fetch(0, 255, '0);
    fetch(2, 210, '0);
    fetch(2, 5, '0);
    fetch(1, 3, '0);
    tick();
    check_int("fetch_valid drops dut0", int'(fv[0]), 0);

    // Load and fetch.
    start_load(0);
    check_int("load_ready in LOAD", int'(lr[0]), 1);
    check_int("cpu_hold in LOAD", int'(ch[0]), 1);
    send(0, 35'h1, 1'b0);
    send(0, 35'h2, 1'b0);
    send(0, 35'h4, 1'b1);
    count_done(0, 300, p);
    check_int("load_done pulses", p, 1);
    check_word("checksum 1^2^4", cs[0], 35'h7);
    check_int("load_err clean load", int'(le[0]), 0);
    check_int("cpu_hold after load", int'(ch[0]), 0);
    fetch(0, 1, 35'h2);
    fetch(0, 3, '0);
    fetch(0, 0, 35'h1);
    fetch(0, 2, 35'h4);
    tick();
    check_word("fetch_data hold 1", fd[0], 35'h4);
    tick();
    check_word("fetch_data hold 2", fd[0], 35'h4);
    check_int("fetch_valid idle", int'(fv[0]), 0);

    // Backpressure; a stray load_start and fetch during LOAD must be ignored.
    start_load(0);
    send(0, 35'h4_0000_0003, 1'b0);
    ls[0] = 1'b1; fe[0] = 1'b1; fa[0] = 8'd0;
    tick();
    ls[0] = 1'b0; fe[0] = 1'b0;
    check_word("fetch during LOAD data", fd[0], '0);
    check_int("fetch during LOAD valid", int'(fv[0]), 0);
    send(0, 35'h0_000F_00F0, 1'b1);
    count_done(0, 300, p);
    check_int("load_done backpressure", p, 1);
    check_word("checksum backpressure", cs[0], 35'h4_000F_00F3);
    fetch(0, 0, 35'h4_0000_0003);
    fetch(0, 1, 35'h0_000F_00F0);
    fetch(0, 2, '0);

    // Overflow on DEPTH=4.
    start_load(1);
    send(1, 35'h11, 1'b0);
    send(1, 35'h22, 1'b0);
    send(1, 35'h44, 1'b0);
    send(1, 35'h88, 1'b0);
    send(1, 35'h100, 1'b0);
    send(1, 35'h200, 1'b1);
    count_done(1, 20, p);
    check_int("load_done overflow", p, 1);
    check_int("load_err overflow", int'(le[1]), 1);
    check_word("checksum overflow", cs[1], 35'hFF);
    fetch(1, 0, 35'h11);
    fetch(1, 1, 35'h22);
    fetch(1, 2, 35'h44);
    fetch(1, 3, 35'h88);
    fetch(1, 5, '0);
    start_load(1);
    check_int("load_err cleared by load_start", int'(le[1]), 0);
    send(1, 35'h3, 1'b1);
    count_done(1, 20, p);
    check_word("checksum single word", cs[1], 35'h3);

    // Reset mid-load.
    start_load(0);
    send(0, 35'h7, 1'b0);
    send(0, 35'h9, 1'b0);
    rst_n = 1'b0;
    tick();
    check_int("cpu_hold in reset", int'(ch[0]), 1);
    check_int("load_ready in reset", int'(lr[0]), 0);
    check_word("checksum in reset", cs[0], '0);
    tick();
    rst_n = 1'b1;
    wait_idle(0, 400, n);
    check_int("clear cycles after mid-load reset", n, 256);
    fetch(0, 0, '0);
    fetch(0, 1, '0);
    fetch(0, 2, '0);
    fetch(0, 100, '0);
    fetch(1, 0, '0);
    tick();
    tick();
    check_int("scoreboard dut0 drained", exp_q0.size(), 0);
    check_int("scoreboard dut1 drained", exp_q1.size(), 0);
    check_int("scoreboard dut2 drained", exp_q2.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_mem.md
PROG_MEM -- requirements
Module: prog_mem

Interface
REQ-001 The block SHALL have parameter DATA_W, default 35, giving the instruction word width.
REQ-002 The block SHALL have parameter ADDR_W, default 8, giving the address width.
REQ-003 The block SHALL have parameter DEPTH, default 256, giving the number of words; DEPTH SHALL be at most 2**ADDR_W.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset; the ports are listed in REQ-005 to REQ-019.
REQ-005 Port clk: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-006 Port rst_n: input, 1 bit, asynchronous active-low reset.
REQ-007 Port fetch_en: input, 1 bit, fetch request.
REQ-008 Port fetch_addr: input, ADDR_W bits, fetch address, taken from the CPU IP.
REQ-009 Port fetch_data: output, DATA_W bits, registered instruction word.
REQ-010 Port fetch_valid: output, 1 bit, fetch_data holds a completed fetch.
REQ-011 Port load_start: input, 1 bit, one-cycle pulse that begins a program load.
REQ-012 Port load_valid: input, 1 bit, a load word is offered.
REQ-013 Port load_data: input, DATA_W bits, the load word.
REQ-014 Port load_last: input, 1 bit, marks the final word of the load.
REQ-015 Port load_ready: output, 1 bit, the block accepts a load word.
REQ-016 Port cpu_hold: output, 1 bit, holds the CPU in reset while high.
REQ-017 Port load_done: output, 1 bit, one-cycle pulse when a load completes.
REQ-018 Port load_err: output, 1 bit, sticky overflow flag.
REQ-019 Port checksum: output, DATA_W bits, XOR of all words accepted in the last load.

Function
REQ-020 The FSM SHALL have states CLEAR, IDLE, LOAD and FILL.
REQ-021 CLEAR SHALL write NOP (all zeros) to one address per cycle, from 0 to DEPTH-1, then go to IDLE; it takes DEPTH cycles.
REQ-022 In IDLE, load_start SHALL reset the write pointer and checksum to 0, clear load_err, and move to LOAD.
REQ-023 In LOAD, load_ready SHALL be 1; a word transfers only when load_valid and load_ready are both 1 in the same cycle.
REQ-024 Each transferred word SHALL be written at the write pointer, the pointer incremented, and checksum XORed with the word.
REQ-025 A transfer with load_last=1 SHALL move the FSM to FILL.
REQ-026 FILL SHALL write NOP from the write pointer to DEPTH-1, one word per cycle, then pulse load_done for one cycle and go to IDLE.
REQ-027 If the pointer is already DEPTH when FILL is entered, FILL SHALL last one cycle.
REQ-028 A word transferred while the pointer equals DEPTH SHALL be discarded, set load_err, and leave checksum unchanged; the load still ends on load_last.
REQ-029 load_start outside IDLE SHALL be ignored.
REQ-030 cpu_hold SHALL be 1 in CLEAR, LOAD and FILL, and 0 in IDLE.
REQ-031 In IDLE, fetch_en=1 SHALL give fetch_data = mem[fetch_addr] and fetch_valid=1 on the next cycle (1-cycle latency).
REQ-032 A fetch with fetch_addr >= DEPTH SHALL return NOP with fetch_valid=1.
REQ-033 With fetch_en=0, fetch_data SHALL hold its value and fetch_valid SHALL be 0.
REQ-034 Outside IDLE, fetches SHALL return NOP with fetch_valid=0.
REQ-035 Memory writes SHALL occur only in CLEAR, LOAD and FILL, so fetch and write never conflict.
REQ-036 The write pointer SHALL be ADDR_W+1 bits wide and SHALL NOT wrap.

Reset
REQ-037 When rst_n=0, the FSM SHALL be forced to CLEAR and the write pointer and checksum set to 0.
REQ-038 Reset SHALL set the outputs to: fetch_data=0, fetch_valid=0, load_ready=0, cpu_hold=1, load_done=0, load_err=0.
REQ-039 Reset during LOAD or FILL SHALL abort the load; the full CLEAR sweep then repeats after rst_n goes high.
REQ-040 The memory array SHALL have no reset term, so it can infer block RAM.

Structure
REQ-041 The NOP encoding and the FSM state encoding SHALL be defined in the shared CPU header and package, next to the instruction-field macros.
REQ-042 Storage SHALL be one sub-module, prog_mem_ram: a single-port synchronous RAM with registered read, parametrised by DATA_W and DEPTH.
REQ-043 The FSM, write pointer and checksum SHALL be in prog_mem.

Verification
REQ-044 Scenario (reset and clear): release rst_n, wait DEPTH cycles, fetch addresses 0, 100 and 255 -> cpu_hold falls after exactly 256 cycles; all fetches return 0.
REQ-045 Scenario (load and fetch): load three words 35'h1, 35'h2 and 35'h4 with the last one flagged -> checksum=35'h7, load_done pulses once, fetch 1 returns 35'h2, fetch 3 returns 0.
REQ-046 Scenario (backpressure): toggle load_valid 1,0,1,0 with load_last on the second word -> exactly 2 words are written, and the idle cycles do not change the pointer.
REQ-047 Scenario (overflow): with DEPTH=4, load 6 words -> load_err=1, words 0-3 are stored, and checksum covers the first 4 words only.
REQ-048 Scenario (reset mid-load): assert rst_n low after 2 of 5 words -> the CLEAR sweep runs again, and all addresses read 0 afterwards.
REQ-049 Scenario (out-of-range fetch): with DEPTH=200, fetch address 210 -> fetch_data=0 and fetch_valid=1 one cycle later.
